axis_read_data_trim: RTL

Successor to the AXI read-data narrowing stage. It accepts wide AXI read beats, buffers them in a FIFO, and serialises each beat into WIDTH_RATIO narrow stream words. Unlike the previous generation, it supports a configurable start-word offset within the first beat and trims excess words past cfg_length. It also generates a stream `last` flag and drains any surplus AXI beats up to rlast. It sits between the AXI HP read channel and the narrow AXI-Stream consumer in the read path.

---
 rtl/axis_read_data_trim.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/axis_read_data_trim.sv
// axis_read_data_trim: buffers wide AXI read beats and serialises them into
// narrow stream words, honouring a start-word offset in the first beat,
// trimming after cfg_length words, flagging the final word with `last`, and
// draining any surplus beats up to rlast.
module axis_read_data_trim #(
  parameter int BUF_AWIDTH     = 4,
  parameter int CFG_DWIDTH     = 32,
  parameter int WIDTH_RATIO    = 8,
  parameter int AXI_DATA_WIDTH = 256,
  parameter int DATA_WIDTH     = 32,
  parameter int OFF_WIDTH      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CFG_DWIDTH-1:0]     cfg_length,
  input  logic [OFF_WIDTH-1:0]      cfg_offset,
  input  logic                      cfg_val,
  output logic                      cfg_rdy,
  input  logic [AXI_DATA_WIDTH-1:0] axi_rdata,
  input  logic                      axi_rlast,
  input  logic                      axi_rvalid,
  output logic                      axi_rready,
  output logic [DATA_WIDTH-1:0]     data,
  output logic                      valid,
  output logic                      last,
  input  logic                      ready
);

  localparam int DEPTH = 1 << BUF_AWIDTH;
  localparam logic [OFF_WIDTH-1:0] LAST_IDX = OFF_WIDTH'(WIDTH_RATIO - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;

  state_t state, next_state;

  logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];
  logic [BUF_AWIDTH-1:0]     wr_ptr, rd_ptr;
  logic [BUF_AWIDTH:0]       count;
  logic                      fifo_full, fifo_empty;

  logic [OFF_WIDTH-1:0]      word_idx;
  logic [CFG_DWIDTH-1:0]     len_cnt;
  logic                      rlast_seen;

  logic [DATA_WIDTH-1:0]     data_r;
  logic                      valid_r, last_r;

  logic                      cfg_hs, axi_hs, out_xfer, final_xfer;
  logic                      slot_free, load, pop, push, underrun, flush;
  logic                      next_last;
  logic [AXI_DATA_WIDTH-1:0] head_beat;
  logic [DATA_WIDTH-1:0]     cur_word;

  assign fifo_full  = count[BUF_AWIDTH];
  assign fifo_empty = (count == '0);

  assign cfg_hs     = cfg_val & cfg_rdy;
  assign axi_hs     = axi_rvalid & axi_rready;
  assign out_xfer   = valid_r & ready;
  assign final_xfer = out_xfer & last_r;

  // The output register can accept a new word when empty or when its current
  // non-final word leaves this cycle; nothing is loaded behind the last word.
  assign slot_free  = ~valid_r | (ready & ~last_r);
  assign load       = (state == ACTIVE) & slot_free & ~fifo_empty;
  assign pop        = load & (word_idx == LAST_IDX);
  assign push       = (state == ACTIVE) & axi_hs & ~final_xfer;
  assign underrun   = (state == ACTIVE) & rlast_seen & fifo_empty & slot_free;
  assign flush      = final_xfer | underrun;

  assign head_beat  = mem[rd_ptr];
  assign cur_word   = head_beat[int'(word_idx)*DATA_WIDTH +: DATA_WIDTH];

  // Length counter is decremented on transfer, so the word loaded now is the
  // last one when exactly one word remains after any concurrent transfer.
  assign next_last  = out_xfer ? (len_cnt == CFG_DWIDTH'(2)) : (len_cnt == CFG_DWIDTH'(1));

  assign data  = data_r;
  assign valid = valid_r;
  assign last  = last_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    next_state = state;
    axi_rready = 1'b0;
    cfg_rdy    = 1'b0;
    unique case (state)
      IDLE: begin
        cfg_rdy = ~rst;
        if (cfg_hs && (cfg_length != '0)) next_state = ACTIVE;
      end
      ACTIVE: begin
        axi_rready = ~rst & ~fifo_full & ~rlast_seen;
        if (final_xfer)
          next_state = (rlast_seen | (axi_hs & axi_rlast)) ? IDLE : DRAIN;
        else if (underrun)
          next_state = IDLE;
      end
      DRAIN: begin
        axi_rready = ~rst;
        if (axi_rvalid && axi_rlast) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat storage; contents need no reset because occupancy is tracked separately.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= axi_rdata;
  end

  // FIFO pointers, serialiser position, length tracking and output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      word_idx   <= '0;
      len_cnt    <= '0;
      rlast_seen <= 1'b0;
      data_r     <= '0;
      valid_r    <= 1'b0;
      last_r     <= 1'b0;
    end else begin
      if (cfg_hs) begin
        len_cnt    <= cfg_length;
        word_idx   <= cfg_offset;
        rlast_seen <= 1'b0;
      end

      if (state == ACTIVE) begin
        if (axi_hs && axi_rlast) rlast_seen <= 1'b1;
        if (out_xfer && (len_cnt != '0)) len_cnt <= len_cnt - 1'b1;

        if (load) begin
          data_r   <= cur_word;
          valid_r  <= 1'b1;
          last_r   <= next_last;
          word_idx <= word_idx + 1'b1;
        end else if (out_xfer) begin
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end

        if (flush) begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count   <= '0;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end else begin
          if (push) wr_ptr <= wr_ptr + 1'b1;
          if (pop)  rd_ptr <= rd_ptr + 1'b1;
          unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
          endcase
        end
      end else begin
        valid_r <= 1'b0;
        last_r  <= 1'b0;
      end
    end
  end

endmodule
